// File: rtl/amount_entry.sv
// amount_entry: turns decoded keypad events into a validated charge amount.
// The user types up to two BCD digits, and confirm checks them against MAX_VALUE.
// An accepted amount is handed off with a one-cycle strobe. The current entry is
// shown on the BCD display outputs.
module amount_entry #(
  parameter int MAX_VALUE   = 20,
  parameter int TIMEOUT_CYC = 100000000,
  parameter int TO_W        = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_value,
  input  logic       press_num,
  input  logic       start,
  input  logic       clear,
  input  logic       confirm,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic [1:0] digit_cnt,
  output logic       entry_active,
  output logic       amount_valid,
  output logic [6:0] amount_out,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ENTRY = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [6:0]      MAX_AMT = 7'(MAX_VALUE);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state, state_nx;
  logic [3:0]      tens_nx, ones_nx;
  logic [1:0]      cnt_nx;
  logic [6:0]      amount_nx;
  logic            valid_nx, err_nx;
  logic [TO_W-1:0] to_cnt, to_nx;
  logic            key_event;
  logic [6:0]      value;

  // tens*10 + ones, where tens*10 is built as (tens<<3) + (tens<<1).
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] o);
    return ({3'b000, t} << 3) + ({3'b000, t} << 1) + {3'b000, o};
  endfunction

  assign key_event    = press_num | start | clear | confirm;
  assign value        = bcd_to_bin(digit_tens, digit_ones);
  assign entry_active = (state == S_ENTRY);

  // Next-state and next-output logic; event priority is clear > confirm > start > digit.
  always_comb begin
    state_nx  = state;
    tens_nx   = digit_tens;
    ones_nx   = digit_ones;
    cnt_nx    = digit_cnt;
    amount_nx = amount_out;
    valid_nx  = 1'b0;
    err_nx    = 1'b0;
    to_nx     = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_ENTRY;
          tens_nx  = 4'd0;
          ones_nx  = 4'd0;
          cnt_nx   = 2'd0;
        end
      end
      S_ENTRY: begin
        if (clear || start) begin
          tens_nx = 4'd0;
          ones_nx = 4'd0;
          cnt_nx  = 2'd0;
        end
        if (!clear && confirm) begin
          if (digit_cnt == 2'd0 || value == 7'd0 || value > MAX_AMT) begin
            err_nx  = 1'b1;
            tens_nx = 4'd0;
            ones_nx = 4'd0;
            cnt_nx  = 2'd0;
          end else begin
            state_nx  = S_DONE;
            amount_nx = value;
            valid_nx  = 1'b1;
          end
        end else if (!clear && !start && press_num) begin
          // Out-of-range keys and a third digit are silently dropped.
          if (key_value <= 4'd9 && digit_cnt < 2'd2) begin
            tens_nx = digit_ones;
            ones_nx = key_value;
            cnt_nx  = digit_cnt + 2'd1;
          end
        end
        // Any key event restarts the inactivity window; otherwise count toward abandon.
        if (!key_event) begin
          if (to_cnt == TO_LAST) begin
            state_nx = S_IDLE;
            tens_nx  = 4'd0;
            ones_nx  = 4'd0;
            cnt_nx   = 2'd0;
          end else begin
            to_nx = to_cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (clear) begin
          state_nx  = S_IDLE;
          amount_nx = 7'd0;
          tens_nx   = 4'd0;
          ones_nx   = 4'd0;
          cnt_nx    = 2'd0;
        end else if (start) begin
          state_nx = S_ENTRY;
          tens_nx  = 4'd0;
          ones_nx  = 4'd0;
          cnt_nx   = 2'd0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        tens_nx  = 4'd0;
        ones_nx  = 4'd0;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  // Register state and every output; reset overrides any key event in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      digit_tens   <= 4'd0;
      digit_ones   <= 4'd0;
      digit_cnt    <= 2'd0;
      amount_out   <= 7'd0;
      amount_valid <= 1'b0;
      err          <= 1'b0;
      to_cnt       <= '0;
    end else begin
      state        <= state_nx;
      digit_tens   <= tens_nx;
      digit_ones   <= ones_nx;
      digit_cnt    <= cnt_nx;
      amount_out   <= amount_nx;
      amount_valid <= valid_nx;
      err          <= err_nx;
      to_cnt       <= to_nx;
    end
  end

endmodule
